latency_result_receiver: RTL and testbench

- Receiving end of a fixed-latency, non-handshaked datapath unit (e.g. our pipelined adder box: operands in, `out` valid exactly LATENCY cycles later, no valid, no stall).
- Gates operation issue with credits and tags each issued operation through a LATENCY-deep valid pipeline.
- Captures the unit's result on the tagged cycle into an internal FIFO and presents results downstream on a ready/valid interface.
- Converts a stall-free pipeline into a backpressure-safe stream without ever dropping a result.

---
 rtl/latency_result_receiver.sv | 91 +++++++++
 tb/tb_latency_result_receiver.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/latency_result_receiver.sv
// Receiver for a fixed-latency, stall-free datapath unit. Issued operations are credit-gated
// and tagged, results are captured on the tagged cycle and re-emitted on a ready/valid stream.
module latency_result_receiver #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 4,
    parameter int DEPTH   = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       issue_valid,
    output logic                       issue_ready,
    input  logic [WIDTH-1:0]           result_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CNT_W-1:0]   used_reg, used_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
    logic [LATENCY-1:0] tag_reg, tag_next;
    logic [WIDTH-1:0]   mem_reg [DEPTH];

    logic issue_fire;
    logic pop_fire;
    logic capture;

    // Credit check uses only registered state so issue_ready has no combinational input path.
    assign issue_ready = (used_reg < CNT_W'(DEPTH));
    assign issue_fire  = issue_valid && issue_ready;
    assign out_valid   = (count_reg != '0);
    assign pop_fire    = out_valid && out_ready;
    assign capture     = tag_reg[LATENCY-1];
    assign out_data    = mem_reg[rd_ptr_reg];
    assign occupancy   = count_reg;

    assign tag_next[0] = issue_fire;
    generate
        for (genvar gi = 1; gi < LATENCY; gi++) begin : g_tag
            assign tag_next[gi] = tag_reg[gi-1];
        end
    endgenerate

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        if (capture) begin
            wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
        end
        if (pop_fire) begin
            rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;
        end
        count_next = count_reg + CNT_W'(capture) - CNT_W'(pop_fire);
        used_next  = used_reg + CNT_W'(issue_fire) - CNT_W'(pop_fire);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            used_reg   <= '0;
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            tag_reg    <= '0;
        end else begin
            used_reg   <= used_next;
            count_reg  <= count_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            tag_reg    <= tag_next;
        end
    end

    // Storage has no reset; pointers and count define which entries are live.
    always_ff @(posedge clock) begin
        if (capture) begin
            mem_reg[wr_ptr_reg] <= result_in;
        end
    end

    // Credits reserve a slot for every tagged result, so a capture into a full FIFO is a bug.
    a_no_overflow: assert property (@(posedge clock) disable iff (reset)
        !(capture && (count_reg == CNT_W'(DEPTH)) && !pop_fire));
    a_used_bound: assert property (@(posedge clock) disable iff (reset)
        used_reg <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_latency_result_receiver.sv
// Bench for latency_result_receiver: models the adder unit, scores results in issue order,
// and exercises directed vectors, streaming, backpressure, small-DEPTH credits and reset.
module tb_latency_result_receiver;

    localparam int W = 32;
    localparam int L = 4;
    localparam int D = 8;

    logic          clock;
    logic          reset;
    logic          iv, ir, ov, ordy;
    logic [W-1:0]  a, b, result_in, odata;
    logic [3:0]    occ;

    logic          iv3, ir3, ov3, ordy3;
    logic [W-1:0]  a3, res3, od3;
    logic [1:0]    occ3;

    logic [W-1:0]  pipe  [L];
    logic [W-1:0]  pipe3 [L];
    logic [W-1:0]  sb [$];

    int tests, fails, used_m;
    int acc, n3, exp3, first_c, last_c, ov_cnt, stale;

    typedef struct {
        logic         iv;
        logic         ordy;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         exp_ir;
        logic         exp_ov;
        logic [3:0]   exp_occ;
        logic         chk_data;
        logic [W-1:0] exp_data;
    } vec_t;
    vec_t vecs [10];

    latency_result_receiver #(.WIDTH(W), .LATENCY(L), .DEPTH(D)) dut (
        .clock(clock), .reset(reset), .issue_valid(iv), .issue_ready(ir),
        .result_in(result_in), .out_valid(ov), .out_ready(ordy),
        .out_data(odata), .occupancy(occ)
    );

    latency_result_receiver #(.WIDTH(W), .LATENCY(L), .DEPTH(3)) dut3 (
        .clock(clock), .reset(reset), .issue_valid(iv3), .issue_ready(ir3),
        .result_in(res3), .out_valid(ov3), .out_ready(ordy3),
        .out_data(od3), .occupancy(occ3)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Fixed-latency unit models: compute every cycle, no valid, no stall.
    always @(posedge clock) begin
        pipe[0]  <= a + b;
        pipe3[0] <= a3;
        for (int i = 1; i < L; i++) begin
            pipe[i]  <= pipe[i-1];
            pipe3[i] <= pipe3[i-1];
        end
    end
    assign result_in = pipe[L-1];
    assign res3      = pipe3[L-1];

    function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endfunction

    // Scoreboard and credit model for the DEPTH=8 instance, sampled mid-cycle.
    initial begin
        used_m = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                sb.delete();
                used_m = 0;
            end else begin
                check("credit_ready", ir, (used_m < D));
                if (occ > D) check("occ_bound", occ, D);
                if (ov && ordy) begin
                    if (sb.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL pop_underflow actual=%0d required=nothing", odata);
                    end else begin
                        check("pop_data", odata, sb.pop_front());
                    end
                end
                if (iv && ir) sb.push_back(a + b);
                used_m = used_m + ((iv && ir) ? 1 : 0) - ((ov && ordy) ? 1 : 0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic r);
        @(posedge clock);
        #1;
        iv = v;
        a = x;
        b = y;
        ordy = r;
    endtask

    task automatic drain();
        for (int c = 0; c < 100 && (sb.size() != 0 || ov); c++) begin
            drive(1'b0, $urandom, $urandom, 1'b1);
            @(negedge clock);
        end
        check("drain_empty", sb.size(), 0);
        check("drain_ov", ov, 0);
    endtask

    initial begin
        reset = 1'b1; iv = 1'b0; ordy = 1'b0; a = '0; b = '0;
        iv3 = 1'b0; ordy3 = 1'b1; a3 = '0;
        tests = 0; fails = 0;

        // Single issue 3+5: result visible LATENCY+1 cycles later, held under backpressure.
        for (int i = 0; i < 10; i++) begin
            vecs[i] = '{iv: 1'b0, ordy: 1'b0, a: 32'hdead, b: W'(i), exp_ir: 1'b1,
                        exp_ov: 1'b0, exp_occ: 4'd0, chk_data: 1'b0, exp_data: '0};
        end
        vecs[0].iv = 1'b1; vecs[0].a = 3; vecs[0].b = 5;
        vecs[5].exp_ov = 1'b1; vecs[5].exp_occ = 4'd1; vecs[5].chk_data = 1'b1; vecs[5].exp_data = 8;
        vecs[6].ordy = 1'b1;
        vecs[6].exp_ov = 1'b1; vecs[6].exp_occ = 4'd1; vecs[6].chk_data = 1'b1; vecs[6].exp_data = 8;

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst_ready", ir, 1);
        check("rst_ov", ov, 0);
        check("rst_occ", occ, 0);

        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].iv, vecs[i].a, vecs[i].b, vecs[i].ordy);
            @(negedge clock);
            check($sformatf("vec%0d_ready", i), ir, vecs[i].exp_ir);
            check($sformatf("vec%0d_ov", i), ov, vecs[i].exp_ov);
            check($sformatf("vec%0d_occ", i), occ, vecs[i].exp_occ);
            if (vecs[i].chk_data) check($sformatf("vec%0d_data", i), odata, vecs[i].exp_data);
        end
        check("vec_used_zero", used_m, 0);

        // Back-to-back stream of i+i with out_ready high.
        first_c = -1; last_c = -1; ov_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            if (c < 20) drive(1'b1, W'(c), W'(c), 1'b1);
            else        drive(1'b0, 32'hbad, 0, 1'b1);
            @(negedge clock);
            if (c < 20) check("b2b_ready", ir, 1);
            if (ov) begin
                if (first_c < 0) begin
                    first_c = c;
                    check("b2b_first", odata, 0);
                end
                last_c = c;
                ov_cnt++;
            end
        end
        check("b2b_count", ov_cnt, 20);
        check("b2b_gapless", last_c - first_c, 19);
        check("b2b_first_cycle", first_c, L + 1);
        drain();

        // Backpressure: exactly DEPTH credits, then release on first pop.
        acc = 0;
        for (int c = 0; c < 16; c++) begin
            drive(1'b1, $urandom, $urandom, 1'b0);
            @(negedge clock);
            if (ir) acc++;
            check("bp_ov_stable", ov, (c >= L + 1));
        end
        check("bp_accepts", acc, D);
        check("bp_ready_low", ir, 0);
        check("bp_occ", occ, D);
        drive(1'b1, $urandom, $urandom, 1'b1);
        @(negedge clock);
        check("bp_first_pop_ready", ir, 0);
        drive(1'b0, $urandom, $urandom, 1'b1);
        @(negedge clock);
        check("bp_ready_back", ir, 1);
        drain();

        // Random traffic against the scoreboard.
        for (int c = 0; c < 2000; c++) begin
            drive(1'($urandom_range(0, 1)), $urandom, $urandom, 1'($urandom_range(0, 1)));
        end
        drain();

        // DEPTH=3 instance: 3 accepts per 6 cycles, strictly ordered.
        n3 = 0; exp3 = 0;
        for (int c = 0; c < 70; c++) begin
            @(posedge clock);
            #1;
            iv3 = (c < 60);
            a3 = W'(n3);
            @(negedge clock);
            if (iv3 && ir3) n3++;
            if (ov3) begin
                check("d3_order", od3, W'(exp3));
                exp3++;
            end
            if (occ3 > 3) check("d3_occ_bound", occ3, 3);
        end
        check("d3_accepts", n3, 30);
        check("d3_popped", exp3, 30);
        iv3 = 1'b0;

        // Reset mid-stream: 2 results in FIFO, 3 in flight, issue held during reset.
        drive(1'b1, $urandom, $urandom, 1'b0);
        drive(1'b1, $urandom, $urandom, 1'b0);
        for (int c = 0; c < 20 && occ != 2; c++) begin
            drive(1'b0, $urandom, $urandom, 1'b0);
            @(negedge clock);
        end
        check("mr_occ2", occ, 2);
        for (int c = 0; c < 3; c++) drive(1'b1, $urandom, $urandom, 1'b0);
        drive(1'b1, $urandom, $urandom, 1'b0);
        reset = 1'b1;
        drive(1'b0, $urandom, $urandom, 1'b1);
        reset = 1'b0;
        @(negedge clock);
        check("mr_ov", ov, 0);
        check("mr_occ", occ, 0);
        check("mr_ready", ir, 1);
        stale = 0;
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, $urandom, $urandom, 1'b1);
            @(negedge clock);
            if (ov || occ != 0) stale++;
        end
        check("mr_no_stale", stale, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
